// File: rtl/seq_cpu_oci_pkg.sv
// seq_cpu_oci_pkg: shared types, RAM geometry, control address and jdo field positions
// for the OCI monitor memory.
package seq_cpu_oci_pkg;
    localparam int RAM_DEPTH = 256;
    localparam int RAM_WIDTH = 32;
    localparam int RAM_AW = 8;
    localparam logic [8:0] CTRL_ADDR = 9'h100;
    localparam int JDO_ADDR_LO = 17;
    localparam int JDO_ADDR_HI = 24;
    localparam int JDO_DATA_LO = 3;
    localparam int JDO_DATA_HI = 34;
    localparam int JDO_GO = 35;
    localparam int JDO_CLR = 36;
    typedef enum logic [1:0] {S_IDLE, S_CPU_RD, S_CPU_ACK, S_JTAG_RD} state_e;
    typedef enum logic [1:0] {OP_NONE, OP_A, OP_B, OP_N} op_e;
endpackage

// File: rtl/seq_cpu_oci_ram.sv
// seq_cpu_oci_ram: single-port monitor RAM with byte enables and a registered read port.
module seq_cpu_oci_ram
    import seq_cpu_oci_pkg::*;
(
    input  logic                   clk,
    input  logic                   we_i,
    input  logic [RAM_AW-1:0]      addr_i,
    input  logic [RAM_WIDTH-1:0]   wdata_i,
    input  logic [RAM_WIDTH/8-1:0] be_i,
    output logic [RAM_WIDTH-1:0]   rdata_o
);
    logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < RAM_WIDTH / 8; i++)
            if (we_i && be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/seq_cpu_oci_monitor_mem.sv
// seq_cpu_oci_monitor_mem: OCI monitor RAM and control register shared by JTAG and a CPU slave port.
// Define OCI_RAM_DEBUGACCESS_EN to make CPU RAM writes require debugaccess.
module seq_cpu_oci_monitor_mem
    import seq_cpu_oci_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic        take_no_action_ocimem_a,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [8:0]  address,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    input  logic        debugaccess,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error,
    output logic        monitor_go
);
    state_e state_q, state_d;
    op_e pend_op_q, pend_op_d, strobe_op, exec_op;
    logic [JDO_CLR:JDO_DATA_LO] pend_jdo_q, pend_jdo_d, exec_jdo;
    logic [7:0] mon_a_q, mon_a_d, ram_addr;
    logic [31:0] mon_d_q, mon_d_d, rdata_q, rdata_d, ram_rdata, ram_wdata, ctrl_rd;
    logic ready_q, ready_d, error_q, error_d, go_q, go_d;
    logic pend_valid, is_idle, accept, cpu_wr, ram_we, ram_cpu_we;
    logic [3:0] ram_be;
    logic unused_jdo;

    assign unused_jdo = ^{jdo[37], jdo[2:0]};
    assign strobe_op = take_action_ocimem_a ? OP_A :
                       take_action_ocimem_b ? OP_B :
                       take_no_action_ocimem_a ? OP_N : OP_NONE;
    assign pend_valid = pend_op_q != OP_NONE;
    assign is_idle = state_q == S_IDLE;
    // A deferred strobe runs before any new one; the new one then refills the slot.
    assign exec_op = !is_idle ? OP_NONE : pend_valid ? pend_op_q : strobe_op;
    assign exec_jdo = pend_valid ? pend_jdo_q : jdo[JDO_CLR:JDO_DATA_LO];
    assign accept = is_idle && strobe_op == OP_NONE && !pend_valid && chipselect && (read || write);
    assign cpu_wr = accept && write;
`ifdef OCI_RAM_DEBUGACCESS_EN
    assign ram_cpu_we = cpu_wr && !address[8] && debugaccess;
`else
    logic unused_dbg;
    assign unused_dbg = debugaccess;
    assign ram_cpu_we = cpu_wr && !address[8];
`endif
    assign ram_we = exec_op == OP_B || ram_cpu_we;
    assign ram_addr = exec_op != OP_NONE ? mon_a_q : address[7:0];
    assign ram_wdata = exec_op == OP_B ? exec_jdo[JDO_DATA_HI:JDO_DATA_LO] : writedata;
    assign ram_be = exec_op == OP_B ? 4'hF : byteenable;
    assign ctrl_rd = {29'b0, go_q, error_q, ready_q};

    seq_cpu_oci_ram u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .be_i    (ram_be),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        pend_op_d = pend_op_q;
        pend_jdo_d = pend_jdo_q;
        mon_a_d = mon_a_q;
        mon_d_d = mon_d_q;
        rdata_d = rdata_q;
        ready_d = ready_q;
        error_d = error_q;
        go_d = go_q;
        state_d = is_idle ? (exec_op == OP_N ? S_JTAG_RD : accept ? (write ? S_CPU_ACK : S_CPU_RD) : S_IDLE) :
                  state_q == S_CPU_RD ? S_CPU_ACK : S_IDLE;
        if (is_idle ? pend_valid : (strobe_op != OP_NONE && !pend_valid)) begin
            pend_op_d = strobe_op;
            pend_jdo_d = jdo[JDO_CLR:JDO_DATA_LO];
        end
        if (!is_idle && strobe_op != OP_NONE && pend_valid) error_d = 1'b1;
        if (exec_op == OP_A) begin
            mon_a_d = exec_jdo[JDO_ADDR_HI:JDO_ADDR_LO];
            go_d = go_q | exec_jdo[JDO_GO];
            ready_d = ready_q & ~exec_jdo[JDO_CLR];
            error_d = error_q & ~exec_jdo[JDO_CLR];
        end
        if (exec_op == OP_B || state_q == S_JTAG_RD) mon_a_d = mon_a_q + 8'd1;
        if (state_q == S_JTAG_RD) mon_d_d = ram_rdata;
        if (state_q == S_CPU_RD) rdata_d = !address[8] ? ram_rdata : address == CTRL_ADDR ? ctrl_rd : '0;
        if (cpu_wr && address == CTRL_ADDR) begin
            ready_d = writedata[0];
            error_d = writedata[1];
            go_d = go_q & ~writedata[2];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pend_op_q <= OP_NONE;
            pend_jdo_q <= '0;
            mon_a_q <= '0;
            mon_d_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            go_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_op_q <= pend_op_d;
            pend_jdo_q <= pend_jdo_d;
            mon_a_q <= mon_a_d;
            mon_d_q <= mon_d_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            error_q <= error_d;
            go_q <= go_d;
        end
    end

    assign readdata = rdata_q;
    assign waitrequest = state_q != S_CPU_ACK;
    assign MonDReg = mon_d_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;
    assign monitor_go = go_q;
endmodule

// File: tb/tb_seq_cpu_oci_monitor_mem.sv
// tb_seq_cpu_oci_monitor_mem: scoreboard bench for the OCI monitor memory (JTAG ops, CPU port, arbitration, reset).
module tb_seq_cpu_oci_monitor_mem;
    import seq_cpu_oci_pkg::*;

    logic clk = 0, reset_n = 0;
    logic [37:0] jdo = '0;
    logic take_action_ocimem_a = 0, take_action_ocimem_b = 0, take_no_action_ocimem_a = 0;
    logic chipselect = 0, read = 0, write = 0, debugaccess = 0;
    logic [8:0] address = '0;
    logic [31:0] writedata = '0;
    logic [3:0] byteenable = '0;
    logic [31:0] readdata, MonDReg;
    logic waitrequest, monitor_ready, monitor_error, monitor_go;

    int vectors = 0, miscompares = 0;
    logic [31:0] m_mem [256];
    logic [7:0] m_areg = '0;
    logic [31:0] m_mond = '0;
    logic m_rdy = 0, m_err = 0, m_go = 0;
    logic [31:0] cpu_exp [$];
    logic [31:0] jtag_exp [$];

    seq_cpu_oci_monitor_mem dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .chipselect(chipselect), .read(read), .write(write), .address(address),
        .writedata(writedata), .byteenable(byteenable), .debugaccess(debugaccess),
        .readdata(readdata), .waitrequest(waitrequest), .MonDReg(MonDReg),
        .monitor_ready(monitor_ready), .monitor_error(monitor_error), .monitor_go(monitor_go)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_rd(input logic [8:0] a);
        return a == 9'h100 ? {29'b0, m_go, m_err, m_rdy} : a[8] ? 32'h0 : m_mem[a[7:0]];
    endfunction

    task automatic model_wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be, input logic dbg);
        bit en;
        en = 1;
`ifdef OCI_RAM_DEBUGACCESS_EN
        en = dbg;
`endif
        if (a == 9'h100) begin
            m_rdy = d[0];
            m_err = d[1];
            if (d[2]) m_go = 0;
        end else if (!a[8] && en)
            for (int i = 0; i < 4; i++) if (be[i]) m_mem[a[7:0]][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic jtag_a(input logic [7:0] a, input logic go, input logic clr);
        jdo = '0;
        jdo[24:17] = a;
        jdo[35] = go;
        jdo[36] = clr;
        take_action_ocimem_a = 1;
        tick();
        take_action_ocimem_a = 0;
        m_areg = a;
        if (go) m_go = 1;
        if (clr) begin m_rdy = 0; m_err = 0; end
    endtask

    task automatic jtag_b(input logic [31:0] d);
        jdo = '0;
        jdo[34:3] = d;
        take_action_ocimem_b = 1;
        tick();
        take_action_ocimem_b = 0;
        m_mem[m_areg] = d;
        m_areg = m_areg + 8'd1;
    endtask

    task automatic jtag_n(output logic [31:0] d1, output logic [31:0] d2);
        jtag_exp.push_back(m_mem[m_areg]);
        m_areg = m_areg + 8'd1;
        take_no_action_ocimem_a = 1;
        tick();
        take_no_action_ocimem_a = 0;
        d1 = MonDReg;
        tick();
        d2 = MonDReg;
    endtask

    // Holds the request until the cycle waitrequest is seen low, then counts how long it stays low.
    task automatic cpu_xfer(input logic [8:0] a, input logic wr, input logic [31:0] d, input logic [3:0] be,
                            input logic dbg, input logic nstb, output logic [31:0] rd, output int low, output bit to);
        int n;
        chipselect = 1; read = !wr; write = wr; address = a;
        writedata = d; byteenable = be; debugaccess = dbg;
        take_no_action_ocimem_a = nstb;
        tick();
        take_no_action_ocimem_a = 0;
        n = 0;
        while (waitrequest && n < 20) begin tick(); n++; end
        to = waitrequest;
        rd = readdata;
        low = 0;
        while (!waitrequest && low < 4) begin low++; tick(); end
        chipselect = 0; read = 0; write = 0; debugaccess = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({monitor_go, monitor_error, monitor_ready} !== 3'b0) begin
            miscompares++; $display("FAIL reset_flags: got %b want 000", {monitor_go, monitor_error, monitor_ready});
        end
        reset_n = 1;
        tick();
        vectors++;
        if (readdata !== 32'h0 || MonDReg !== 32'h0) begin
            miscompares++; $display("FAIL reset_data: readdata %h MonDReg %h want 0", readdata, MonDReg);
        end
        vectors++;
        if (waitrequest !== 1'b1) begin miscompares++; $display("FAIL reset_wait: got %b want 1", waitrequest); end
        vectors++;
        if (dut.mon_a_q !== 8'h00 || dut.state_q !== S_IDLE) begin
            miscompares++; $display("FAIL reset_state: MonAReg %h state %0d want 00/IDLE", dut.mon_a_q, dut.state_q);
        end
    endtask

    task automatic test_jtag_write();
        jtag_a(8'h10, 0, 0);
        jtag_b(32'hDEADBEEF);
        vectors++;
        if (dut.mon_a_q !== m_areg) begin miscompares++; $display("FAIL b_incr: got %h want %h", dut.mon_a_q, m_areg); end
        jtag_a(8'hFF, 0, 0);
        jtag_b(32'hCAFEF00D);
        vectors++;
        if (dut.mon_a_q !== m_areg) begin miscompares++; $display("FAIL b_wrap: got %h want %h", dut.mon_a_q, m_areg); end
    endtask

    task automatic test_jtag_read_wrap();
        logic [31:0] d1, d2, e;
        jtag_a(8'hFF, 0, 0);
        jtag_n(d1, d2);
        e = jtag_exp.pop_front();
        vectors++;
        if (d1 !== m_mond) begin miscompares++; $display("FAIL n_early: got %h want %h", d1, m_mond); end
        vectors++;
        if (d2 !== e) begin miscompares++; $display("FAIL n_data: got %h want %h", d2, e); end
        m_mond = e;
        vectors++;
        if (dut.mon_a_q !== m_areg) begin miscompares++; $display("FAIL n_wrap: got %h want %h", dut.mon_a_q, m_areg); end
    endtask

    task automatic test_priority();
        logic [31:0] rd, e;
        int low;
        bit to;
        jtag_a(8'h10, 0, 0);
        jtag_exp.push_back(m_mem[m_areg]);
        m_areg = m_areg + 8'd1;
        cpu_exp.push_back(model_rd(9'h010));
        cpu_xfer(9'h010, 0, '0, 4'hF, 1, 1, rd, low, to);
        e = jtag_exp.pop_front();
        m_mond = e;
        vectors++;
        if (MonDReg !== e) begin miscompares++; $display("FAIL prio_jtag: MonDReg %h want %h", MonDReg, e); end
        e = cpu_exp.pop_front();
        vectors++;
        if (to || rd !== e) begin miscompares++; $display("FAIL prio_rd: got %h timeout %0d want %h", rd, to, e); end
        vectors++;
        if (low != 1) begin miscompares++; $display("FAIL prio_wait: low for %0d cycles want 1", low); end
        vectors++;
        if (dut.mon_a_q !== m_areg) begin miscompares++; $display("FAIL prio_areg: got %h want %h", dut.mon_a_q, m_areg); end
    endtask

    task automatic test_ctrl();
        logic [31:0] rd, e;
        int low;
        bit to;
        model_wr(9'h100, 32'h3, 4'hF, 1);
        cpu_xfer(9'h100, 1, 32'h3, 4'hF, 1, 0, rd, low, to);
        vectors++;
        if (to || low != 1 || {monitor_go, monitor_error, monitor_ready} !== {m_go, m_err, m_rdy}) begin
            miscompares++; $display("FAIL ctrl_set: got %b low %0d want %b", {monitor_go, monitor_error, monitor_ready}, low, {m_go, m_err, m_rdy});
        end
        cpu_exp.push_back(model_rd(9'h100));
        cpu_xfer(9'h100, 0, '0, 4'hF, 1, 0, rd, low, to);
        e = cpu_exp.pop_front();
        vectors++;
        if (to || rd !== e) begin miscompares++; $display("FAIL ctrl_rd: got %h want %h", rd, e); end
        jtag_a(8'h00, 1, 1);
        vectors++;
        if ({monitor_go, monitor_error, monitor_ready} !== {m_go, m_err, m_rdy}) begin
            miscompares++; $display("FAIL ctrl_clr: got %b want %b", {monitor_go, monitor_error, monitor_ready}, {m_go, m_err, m_rdy});
        end
        model_wr(9'h100, 32'h4, 4'hF, 1);
        cpu_xfer(9'h100, 1, 32'h4, 4'hF, 1, 0, rd, low, to);
        vectors++;
        if (to || {monitor_go, monitor_error, monitor_ready} !== {m_go, m_err, m_rdy}) begin
            miscompares++; $display("FAIL ctrl_go: got %b want %b", {monitor_go, monitor_error, monitor_ready}, {m_go, m_err, m_rdy});
        end
    endtask

    task automatic test_overflow();
        logic [31:0] e;
        vectors++;
        if (monitor_error !== 1'b0) begin miscompares++; $display("FAIL ovf_pre: error %b want 0", monitor_error); end
        cpu_exp.push_back(model_rd(9'h010));
        chipselect = 1; read = 1; address = 9'h010;
        tick();
        jdo = '0; jdo[24:17] = 8'h20; take_action_ocimem_a = 1;
        tick();
        e = cpu_exp.pop_front();
        vectors++;
        if (waitrequest !== 1'b0 || readdata !== e) begin
            miscompares++; $display("FAIL ovf_rd: wait %b data %h want 0/%h", waitrequest, readdata, e);
        end
        jdo[24:17] = 8'h30;
        tick();
        take_action_ocimem_a = 0; chipselect = 0; read = 0;
        m_err = 1;
        m_areg = 8'h20;
        vectors++;
        if (monitor_error !== m_err) begin miscompares++; $display("FAIL ovf_err: got %b want %b", monitor_error, m_err); end
        tick();
        vectors++;
        if (dut.mon_a_q !== m_areg) begin miscompares++; $display("FAIL ovf_drop: MonAReg %h want %h", dut.mon_a_q, m_areg); end
    endtask

    task automatic test_debugaccess();
        logic [31:0] rd, e;
        int low;
        bit to;
        jtag_a(8'h20, 0, 0);
        jtag_b(32'h0BADF00D);
        model_wr(9'h020, 32'h12345678, 4'hF, 0);
        cpu_xfer(9'h020, 1, 32'h12345678, 4'hF, 0, 0, rd, low, to);
        vectors++;
        if (to || low != 1) begin miscompares++; $display("FAIL dbg_hs: timeout %0d low %0d want 0/1", to, low); end
        cpu_exp.push_back(model_rd(9'h020));
        cpu_xfer(9'h020, 0, '0, 4'hF, 0, 0, rd, low, to);
        e = cpu_exp.pop_front();
        vectors++;
        if (to || rd !== e) begin miscompares++; $display("FAIL dbg_ram: got %h want %h", rd, e); end
        model_wr(9'h020, 32'hAABBCCDD, 4'b0101, 1);
        cpu_xfer(9'h020, 1, 32'hAABBCCDD, 4'b0101, 1, 0, rd, low, to);
        cpu_exp.push_back(model_rd(9'h020));
        cpu_xfer(9'h020, 0, '0, 4'hF, 1, 0, rd, low, to);
        e = cpu_exp.pop_front();
        vectors++;
        if (to || rd !== e) begin miscompares++; $display("FAIL be_write: got %h want %h", rd, e); end
        model_wr(9'h155, 32'hFFFFFFFF, 4'hF, 1);
        cpu_xfer(9'h155, 1, 32'hFFFFFFFF, 4'hF, 1, 0, rd, low, to);
        vectors++;
        if (to || low != 1) begin miscompares++; $display("FAIL unmap_hs: timeout %0d low %0d want 0/1", to, low); end
        foreach (cpu_exp[i]) cpu_exp.delete(i);
        cpu_exp.push_back(model_rd(9'h155));
        cpu_exp.push_back(model_rd(9'h1FF));
        cpu_xfer(9'h155, 0, '0, 4'hF, 1, 0, rd, low, to);
        e = cpu_exp.pop_front();
        vectors++;
        if (to || rd !== e) begin miscompares++; $display("FAIL unmap_155: got %h want %h", rd, e); end
        cpu_xfer(9'h1FF, 0, '0, 4'hF, 1, 0, rd, low, to);
        e = cpu_exp.pop_front();
        vectors++;
        if (to || rd !== e) begin miscompares++; $display("FAIL unmap_1ff: got %h want %h", rd, e); end
    endtask

    task automatic test_reset_midread();
        logic [31:0] rd, e;
        int low;
        bit to;
        chipselect = 1; read = 1; address = 9'h010;
        tick();
        reset_n = 0;
        #2;
        m_mond = 0; m_areg = 0; m_rdy = 0; m_err = 0; m_go = 0;
        vectors++;
        if (dut.state_q !== S_IDLE || readdata !== 32'h0 || MonDReg !== m_mond) begin
            miscompares++; $display("FAIL rst_async: state %0d readdata %h MonDReg %h want IDLE/0/0", dut.state_q, readdata, MonDReg);
        end
        vectors++;
        if ({monitor_go, monitor_error, monitor_ready} !== 3'b0) begin
            miscompares++; $display("FAIL rst_flags: got %b want 000", {monitor_go, monitor_error, monitor_ready});
        end
        chipselect = 0; read = 0;
        reset_n = 1;
        tick();
        tick();
        vectors++;
        if (readdata !== 32'h0 || waitrequest !== 1'b1) begin
            miscompares++; $display("FAIL rst_abandon: readdata %h wait %b want 0/1", readdata, waitrequest);
        end
        cpu_exp.push_back(model_rd(9'h010));
        cpu_xfer(9'h010, 0, '0, 4'hF, 1, 0, rd, low, to);
        e = cpu_exp.pop_front();
        vectors++;
        if (to || rd !== e) begin miscompares++; $display("FAIL rst_ram_kept: got %h want %h", rd, e); end
    endtask

    initial begin
        test_reset();
        test_jtag_write();
        test_jtag_read_wrap();
        test_priority();
        test_ctrl();
        test_overflow();
        test_debugaccess();
        test_reset_midread();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
